// File: rtl/obstacle_field_gen_pkg.sv
// Shared types, constants and helpers for the obstacle field generator of the
// 8x16 dot-matrix dodge game. Imported by obstacle_lfsr and obstacle_field_gen.
package obstacle_field_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int ROWS          = 8;
  localparam int COLS          = 16;
  localparam int PLAYER_COL_LO = 0;
  localparam int PLAYER_COL_HI = 1;

  // x^16 + x^14 + x^13 + x^11 + 1 as a right-shifting Fibonacci register:
  // the feedback bit is the XOR of bits 0, 2, 3 and 5 and enters at bit 15.
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam logic [3:0] GAP_SAT = 4'd15;

  function automatic logic [15:0] lfsr_advance(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

  // One column of the frame, row r in bit r.
  function automatic logic [ROWS-1:0] frame_column(input logic [ROWS*COLS-1:0] f,
                                                   input int c);
    logic [ROWS-1:0] col;
    for (int r = 0; r < ROWS; r++) begin
      col[r] = f[r*COLS + c];
    end
    return col;
  endfunction

  // Two-row obstacle starting at row top; at the bottom row only one row fits.
  function automatic logic [ROWS-1:0] obstacle_mask(input logic [2:0] top);
    logic [ROWS-1:0] m;
    m      = {ROWS{1'b0}};
    m[top] = 1'b1;
    if (top != 3'd7) begin
      m[top + 3'd1] = 1'b1;
    end else begin
      m = m;
    end
    return m;
  endfunction

  // True when any lit pixel of the player columns overlaps the 2x2 sprite.
  function automatic logic player_hits(input logic [ROWS*COLS-1:0] f,
                                       input logic [2:0] prow);
    logic [2:0]      top;
    logic [ROWS-1:0] lo_col;
    logic [ROWS-1:0] hi_col;
    top    = (prow == 3'd7) ? 3'd6 : prow;
    lo_col = frame_column(f, PLAYER_COL_LO);
    hi_col = frame_column(f, PLAYER_COL_HI);
    return lo_col[top] | lo_col[top + 3'd1] | hi_col[top] | hi_col[top + 3'd1];
  endfunction

endpackage

// File: rtl/obstacle_field_gen_lfsr.sv
// obstacle_lfsr: free-running 16-bit Fibonacci LFSR that supplies obstacle
// randomness. An all-zero value can never advance, so it reloads the seed.
module obstacle_lfsr
  import obstacle_field_gen_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] value_o
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // Next value, with zero-lockout recovery
  always_comb begin
    if (value_q == 16'h0000) begin
      value_d = SEED;
    end else begin
      value_d = lfsr_advance(value_q);
    end
  end

  // Shift register, advancing every clock in every game state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/obstacle_field_gen.sv
// obstacle_field_gen: generates and scrolls obstacles across the 8x16 field,
// checks them against the 2x2 player sprite and runs the IDLE/RUN/OVER FSM.
// Optional build macro SPEEDUP_EN: step period shrinks as the score grows.
module obstacle_field_gen
  import obstacle_field_gen_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED,
  parameter int unsigned GAP_MIN   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   player_row,
  output logic [127:0] frame,
  output logic         frame_valid,
  output logic         hit,
  output logic         game_over,
  output logic [7:0]   score,
  output logic [1:0]   state
);

  localparam int       CNT_W    = $clog2(TICK_DIV + 1);
  localparam logic [3:0] GAP_INIT = 4'(GAP_MIN);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     tick_q, tick_d;
  logic [3:0]           gap_q, gap_d;
  logic                 pend_q, pend_d;
  logic [ROWS-1:0]      last_q, last_d;
  logic [ROWS*COLS-1:0] frame_q, frame_d;
  logic                 fv_q, fv_d;
  logic                 hit_q, hit_d;
  logic                 go_q, go_d;
  logic [7:0]           score_q, score_d;

  logic [15:0]          lfsr_s;
  logic                 unused_lfsr_s;
  logic                 term_s;
  logic [ROWS-1:0]      mask_s;
  logic [ROWS-1:0]      exit_col_s;
  logic [ROWS-1:0]      near_col_s;

  obstacle_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk),
    .rst_ni  (rst),
    .value_o (lfsr_s)
  );

  assign unused_lfsr_s = ^lfsr_s[15:4];
  assign exit_col_s    = frame_column(frame_q, 0);
  assign near_col_s    = frame_column(frame_q, 1);

`ifdef SPEEDUP_EN
  logic [CNT_W-1:0] period_q, period_d;

  function automatic logic [CNT_W-1:0] period_for(input logic [7:0] sc);
    logic [1:0]       sh;
    logic [CNT_W-1:0] p;
    if (sc[7:3] > 5'd3) begin
      sh = 2'd3;
    end else begin
      sh = sc[4:3];
    end
    p = CNT_W'(TICK_DIV) >> sh;
    if (p == {CNT_W{1'b0}}) begin
      p = CNT_W'(1);
    end else begin
      p = p;
    end
    return p;
  endfunction

  assign term_s = (tick_q == (period_q - CNT_W'(1)));

  // Period selection: only reloaded at a wrap or restart, so a change lands on the next interval
  always_comb begin
    if ((state_q == ST_OVER) && start) begin
      period_d = CNT_W'(TICK_DIV);
    end else if ((state_q == ST_RUN) && term_s) begin
      period_d = period_for(score_q);
    end else begin
      period_d = period_q;
    end
  end

  // Period register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q <= CNT_W'(TICK_DIV);
    end else begin
      period_q <= period_d;
    end
  end
`else
  assign term_s = (tick_q == CNT_W'(TICK_DIV - 1));
`endif

  // FSM next state, scroll step, obstacle generation, collision and scoring
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    last_d  = last_q;
    frame_d = frame_q;
    score_d = score_q;
    fv_d    = 1'b0;
    hit_d   = 1'b0;
    mask_s  = {ROWS{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (term_s) begin
          // A step edge does not raise hit: collision is judged on the new frame next cycle.
          tick_d = {CNT_W{1'b0}};
          if (pend_q) begin
            mask_s = last_q;
            pend_d = 1'b0;
            gap_d  = 4'd0;
          end else if (gap_q < GAP_INIT) begin
            gap_d = gap_q + 4'd1;
          end else if (lfsr_s[0]) begin
            mask_s = obstacle_mask(lfsr_s[3:1]);
            last_d = obstacle_mask(lfsr_s[3:1]);
            pend_d = 1'b1;
            gap_d  = 4'd0;
          end else if (gap_q != GAP_SAT) begin
            gap_d = gap_q + 4'd1;
          end else begin
            gap_d = gap_q;
          end
          for (int r = 0; r < ROWS; r++) begin
            frame_d[r*COLS +: COLS] = {mask_s[r], frame_q[r*COLS + 1 +: COLS-1]};
          end
          // Trailing column of an obstacle leaving: exit column lit, column behind it empty.
          if ((exit_col_s != {ROWS{1'b0}}) && (near_col_s == {ROWS{1'b0}}) &&
              (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
          end else begin
            score_d = score_q;
          end
          fv_d = 1'b1;
        end else begin
          tick_d = tick_q + CNT_W'(1);
          if (player_hits(frame_q, player_row)) begin
            hit_d   = 1'b1;
            state_d = ST_OVER;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d = ST_RUN;
          frame_d = {(ROWS*COLS){1'b0}};
          score_d = 8'd0;
          tick_d  = {CNT_W{1'b0}};
          gap_d   = 4'd0;
          pend_d  = 1'b0;
          fv_d    = 1'b1;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    go_d = (state_d == ST_OVER);
  end

  // State and output registers; asynchronous reset aborts a run immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tick_q  <= {CNT_W{1'b0}};
      gap_q   <= GAP_INIT;
      pend_q  <= 1'b0;
      last_q  <= {ROWS{1'b0}};
      frame_q <= {(ROWS*COLS){1'b0}};
      fv_q    <= 1'b0;
      hit_q   <= 1'b0;
      go_q    <= 1'b0;
      score_q <= 8'd0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      hit_q   <= hit_d;
      go_q    <= go_d;
      score_q <= score_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign hit         = hit_q;
  assign game_over   = go_q;
  assign score       = score_q;
  assign state       = state_q;

endmodule
